// File: rtl/fifo_share_pkg.sv
// fifo_share_pkg: state encoding and sizing helpers shared by fifo_share_ctrl and its arbiter
package fifo_share_pkg;
  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fifo_share_ctrl_if.sv
// fifo_share_ctrl_if: producer, consumer, flush and Fifo-port signals of the shared Fifo controller
interface fifo_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [N_REQ*DATA_WIDTH-1:0] req_data;
  logic cons_req;
  logic cons_valid;
  logic [DATA_WIDTH-1:0] cons_data;
  logic flush;
  logic flush_done;
  logic [$clog2(DEPTH)-1:0] level;
  logic fifo_wr_enable;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic fifo_rd_enable;
  logic [DATA_WIDTH-1:0] fifo_data_out;
  logic fifo_full;
  logic fifo_empty;
  modport master (
    input req, req_data, cons_req, flush, fifo_data_out, fifo_full, fifo_empty,
    output grant, cons_valid, cons_data, flush_done, level, fifo_wr_enable, fifo_data_in, fifo_rd_enable
  );
  modport slave (
    output req, req_data, cons_req, flush, fifo_data_out, fifo_full, fifo_empty,
    input grant, cons_valid, cons_data, flush_done, level, fifo_wr_enable, fifo_data_in, fifo_rd_enable
  );
endinterface

// File: rtl/fifo_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr
module rr_arbiter
  import fifo_share_pkg::*;
#(
  parameter int N = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [N-1:0] rot;
  logic [IW-1:0] k;
  logic [IW:0] sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    k = '0;
    for (int i = N - 1; i >= 0; i--) if (rot[i]) k = IW'(i);
    sum = {1'b0, ptr} + {1'b0, k};
    grant_idx = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    grant = (en && |req) ? (N'(1) << grant_idx) : '0;
  end
endmodule

// File: rtl/fifo_share_ctrl.sv
// fifo_share_ctrl: round-robin sharing of one Fifo between N_REQ producers and one consumer, with flush drain
module fifo_share_ctrl
  import fifo_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic reset,
  fifo_share_ctrl_if.master bus
);
  localparam int IW = idx_w(N_REQ);
  localparam int LW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [IW-1:0] rr_ptr, gidx;
  logic [N_REQ-1:0] grant;
  logic [LW-1:0] level;
  logic in_run, wr, rd, cons_valid, flush_done;
  assign in_run = (state == ST_RUN) && !reset;
  rr_arbiter #(.N(N_REQ)) u_arb (
    .req(bus.req),
    .ptr(rr_ptr),
    .en(in_run && !bus.fifo_full),
    .grant(grant),
    .grant_idx(gidx)
  );
  always_comb begin
    state_nx = (state == ST_RUN) ? (bus.flush ? ST_FLUSH : ST_RUN) : (bus.fifo_empty ? ST_RUN : ST_FLUSH);
    wr = |grant;
    rd = !reset && !bus.fifo_empty && (bus.cons_req || state == ST_FLUSH);
  end
  // cons_valid marks a consumer read issued last cycle; flush reads never become valid
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_RUN;
      rr_ptr <= '0;
      level <= '0;
      cons_valid <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state <= state_nx;
      if (wr) rr_ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      level <= (wr && !rd) ? level + 1'b1 : (rd && !wr) ? level - 1'b1 : level;
      cons_valid <= rd && state == ST_RUN;
      flush_done <= state == ST_FLUSH && bus.fifo_empty;
    end
  always_ff @(posedge clk)
    if (!reset) assert (!(wr && !rd && level == LW'(DEPTH - 1)) && !(rd && !wr && level == '0));
  assign bus.grant = grant;
  assign bus.fifo_wr_enable = wr;
  assign bus.fifo_data_in = wr ? bus.req_data[int'(gidx) * DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.fifo_rd_enable = rd;
  assign bus.cons_valid = cons_valid;
  assign bus.cons_data = cons_valid ? bus.fifo_data_out : '0;
  assign bus.flush_done = flush_done;
  assign bus.level = level;
endmodule
